vidmem_frame_scheduler: RTL

Wishbone master that sequences flash-to-SPRAM frame loads through the video memory block's register window. On each frame tick it programs the flash read address, length and SPRAM save address, starts the transfer and polls for completion. It ping-pongs between two SPRAM frame buffers and advances a looping frame index, so the LED scan-out always reads a complete frame. It sits on the system Wishbone bus beside the CPU master and is granted by the existing bus arbiter.

---
 rtl/vidmem_frame_scheduler_pkg.sv | 27 ++
 rtl/vidmem_frame_scheduler_if.sv | 14 +
 rtl/vidmem_frame_scheduler_wb_single_master.sv | 60 ++++++
 rtl/vidmem_frame_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vidmem_frame_scheduler_pkg.sv
// Register map of the video memory window, plus the frame-index helper for vidmem_frame_scheduler.
package vidmem_frame_scheduler_pkg;

  localparam logic [15:0] FRAME_MEMORY_START = 16'h2000;

  localparam logic [7:0] VIDMEM_READ_ADDR_LO   = 8'h00;
  localparam logic [7:0] VIDMEM_READ_ADDR_HI   = 8'h01;
  localparam logic [7:0] VIDMEM_READ_LENGTH_LO = 8'h02;
  localparam logic [7:0] VIDMEM_READ_LENGTH_HI = 8'h03;
  localparam logic [7:0] VIDMEM_SAVE_ADDR_LO   = 8'h04;
  localparam logic [7:0] VIDMEM_SAVE_ADDR_HI   = 8'h05;
  localparam logic [7:0] VIDMEM_CONTROL        = 8'h06;
  localparam logic [7:0] VIDMEM_CTRL_START     = 8'h01;

  typedef struct packed {
    logic [7:0] offset;
    logic [7:0] data;
  } reg_write_t;

  // 9-bit increment so idx=255 compares correctly against the frame count.
  function automatic logic [7:0] next_idx(input logic [7:0] idx, input logic [7:0] count);
    logic [8:0] inc;
    inc = {1'b0, idx} + 9'd1;
    return (inc >= {1'b0, count}) ? 8'd0 : inc[7:0];
  endfunction

endpackage

// File: rtl/vidmem_frame_scheduler_if.sv
// 8-bit single-access Wishbone bus between the frame scheduler (master) and the system bus.
interface vidmem_frame_scheduler_if;
  logic [15:0] adr_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        we_o;
  logic        sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;

  modport master (output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, input dat_i, ack_i);
  modport slave  (input adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, output dat_i, ack_i);
endinterface

// File: rtl/vidmem_frame_scheduler_wb_single_master.sv
// Single-access Wishbone engine: latches one request while idle and holds stb/cyc until ack.
module wb_single_master (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  vidmem_frame_scheduler_if.master bus
);

  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (stb_q) begin
      if (bus.ack_i) stb_d = 1'b0;
    end else if (req_i) begin
      stb_d = 1'b1;
      we_d  = we_i;
      adr_d = addr_i;
      dat_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registers update with <= so every flop samples the pre-edge values of the others.
    if (rst_i) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  // The idle cycle after ack falls out of only accepting a request while stb is low.
  assign bus.stb_o = stb_q;
  assign bus.cyc_o = stb_q;
  assign bus.sel_o = stb_q;
  assign bus.we_o  = we_q;
  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;
  assign done_o    = stb_q & bus.ack_i;
  assign rdata_o   = bus.dat_i;

endmodule

// File: rtl/vidmem_frame_scheduler.sv
// Flash-to-SPRAM frame load sequencer with ping-pong buffers and a looping frame index.
// Optional poll watchdog and sticky timeout_err output: define VIDMEM_SCHED_TIMEOUT_EN.
module vidmem_frame_scheduler
  import vidmem_frame_scheduler_pkg::*;
#(
  parameter logic [15:0] VIDMEM_BASE    = 16'h8000,
  parameter logic [15:0] BUF0_ADDR      = FRAME_MEMORY_START + 16'd1024,
  parameter logic [15:0] BUF1_ADDR      = FRAME_MEMORY_START + 16'd2048,
  parameter logic [15:0] FRAME_LEN      = 16'd4,
  parameter logic [15:0] FRAME_STRIDE   = 16'h0400
`ifdef VIDMEM_SCHED_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  vidmem_frame_scheduler_if.master wb,
  input  logic        enable,
  input  logic        tick,
  input  logic        dfu_busy,
  input  logic [15:0] frame_base,
  input  logic [7:0]  frame_count,
  output logic        display_buf,
  output logic [7:0]  frame_idx,
  output logic        load_done,
  output logic        busy,
  output logic [7:0]  overrun
`ifdef VIDMEM_SCHED_TIMEOUT_EN
  , output logic      timeout_err
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_POLL  = 2'd2;
  localparam logic [1:0] ST_SWAP  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        pending_q, pending_d;
  logic [7:0]  overrun_q, overrun_d;
  logic        disp_q, disp_d;
  logic [7:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [15:0] acc_q, acc_d;

  logic        start, poll_clear, to_hit;
  logic        eng_req, eng_we, eng_done;
  logic [15:0] eng_addr, save_addr;
  logic [7:0]  eng_rdata, nidx;
  reg_write_t  step_wr;

`ifdef VIDMEM_SCHED_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        terr_q, terr_d;
  assign to_hit = (to_cnt_q >= TIMEOUT_CYCLES);
`else
  assign to_hit = 1'b0;
`endif

  assign start      = pending_q & enable & ~dfu_busy & (frame_count != 8'd0);
  assign poll_clear = eng_done & ((eng_rdata & VIDMEM_CTRL_START) == 8'h00);
  assign nidx       = next_idx(idx_q, frame_count);
  // Loads always target the buffer the scan-out is not reading.
  assign save_addr  = disp_q ? BUF0_ADDR : BUF1_ADDR;

  // SAVE_ADDR hi must precede lo: the hi-byte write clears the lo byte.
  always_comb begin
    step_wr = '{VIDMEM_CONTROL, VIDMEM_CTRL_START};
    case (step_q)
      3'd0:    step_wr = '{VIDMEM_READ_ADDR_LO, acc_q[7:0]};
      3'd1:    step_wr = '{VIDMEM_READ_ADDR_HI, acc_q[15:8]};
      3'd2:    step_wr = '{VIDMEM_READ_LENGTH_LO, FRAME_LEN[7:0]};
      3'd3:    step_wr = '{VIDMEM_READ_LENGTH_HI, FRAME_LEN[15:8]};
      3'd4:    step_wr = '{VIDMEM_SAVE_ADDR_HI, save_addr[15:8]};
      3'd5:    step_wr = '{VIDMEM_SAVE_ADDR_LO, save_addr[7:0]};
      default: step_wr = '{VIDMEM_CONTROL, VIDMEM_CTRL_START};
    endcase
  end

  // The first write is requested on the IDLE->WRITE edge itself, saving a cycle of tick latency.
  assign eng_we   = (state_q != ST_POLL);
  assign eng_addr = VIDMEM_BASE + {8'h00, (state_q == ST_POLL) ? VIDMEM_CONTROL : step_wr.offset};
  assign eng_req  = ((state_q == ST_IDLE) & start) | (state_q == ST_WRITE) |
                    ((state_q == ST_POLL) & ~to_hit);

  wb_single_master u_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (eng_req),
    .we_i    (eng_we),
    .addr_i  (eng_addr),
    .wdata_i (step_wr.data),
    .done_o  (eng_done),
    .rdata_o (eng_rdata),
    .bus     (wb)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    disp_d    = disp_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
`ifdef VIDMEM_SCHED_TIMEOUT_EN
    to_cnt_d  = '0;
    terr_d    = terr_q;
`endif
    if (tick) begin
      if (pending_q) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else if (enable && (frame_count != 8'd0)) begin
        pending_d = 1'b1;
      end
    end
    case (state_q)
      ST_IDLE: begin
        step_d = '0;
        if (!enable) acc_d = frame_base;
        if (start) begin
          state_d   = ST_WRITE;
          pending_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (eng_done) begin
          if (step_q == 3'd6) begin
            state_d = ST_POLL;
            step_d  = '0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      ST_POLL: begin
`ifdef VIDMEM_SCHED_TIMEOUT_EN
        to_cnt_d = to_hit ? to_cnt_q : to_cnt_q + 24'd1;
`endif
        if (poll_clear) begin
          state_d = ST_SWAP;
          disp_d  = ~disp_q;
          idx_d   = nidx;
          done_d  = 1'b1;
          acc_d   = (nidx == 8'd0) ? frame_base : acc_q + FRAME_STRIDE;
        end
`ifdef VIDMEM_SCHED_TIMEOUT_EN
        // Abort only between reads so no access is left open on the bus.
        else if (to_hit && !wb.stb_o) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= '0;
      disp_q    <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      disp_q    <= disp_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
    end
  end

`ifdef VIDMEM_SCHED_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`endif

  assign display_buf = disp_q;
  assign frame_idx   = idx_q;
  assign load_done   = done_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;

endmodule
